// File: rtl/pixel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_frame_ctrl
//
// Frame sequencer for the 2x2 pixel sensor. Steps one frame through erase,
// expose and ADC-ramp convert phases. It then selects each pixel row in turn
// and captures the two column buses. Each captured row is presented on a
// valid/ready stream.
//
// Parameters
//   ERASE_CYCLES   cycles erase is held high (1..65535)
//   EXPOSE_CYCLES  cycles expose is held high (1..65535)
//   DATA_W         ADC code width; convert lasts 2**DATA_W cycles
//
// Build option
//   GRAY_CODE_EN   when defined, the ramp on data is Gray coded instead of binary
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start        one-cycle frame request, honoured only in IDLE
//   busy         high outside IDLE
//   erase        pixel erase (anaReset)
//   expose       exposure window
//   convert      ADC ramp window
//   read1/read2  row 1 / row 2 drive the column buses
//   data         ADC ramp code, 0 outside convert
//   col1_in      column 1 bus
//   col2_in      column 2 bus
//   out_pixel    captured row {col2, col1}
//   out_row      0 = row 1, 1 = row 2
//   out_valid    out_pixel/out_row valid
//   out_ready    consumer ready
//   frame_done   one-cycle pulse in the final state of a frame
// -----------------------------------------------------------------------------
module pixel_frame_ctrl #(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int DATA_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic                  read1,
  output logic                  read2,
  output logic [DATA_W-1:0]     data,
  input  logic [DATA_W-1:0]     col1_in,
  input  logic [DATA_W-1:0]     col2_in,
  output logic [2*DATA_W-1:0]   out_pixel,
  output logic                  out_row,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  typedef enum logic [3:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    R1_SET,
    R1_OUT,
    R2_SET,
    R2_OUT,
    DONE
  } state_e;

  localparam logic [15:0]     ERASE_LAST  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0]     EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
  // The extra MSB keeps the terminal ramp count distinct from a wrapped zero.
  localparam logic [DATA_W:0] CONV_LAST   = {1'b0, {DATA_W{1'b1}}};

  state_e                state_q, state_d;
  logic [15:0]           phase_cnt_q, phase_cnt_d;
  logic [DATA_W:0]       conv_cnt_q, conv_cnt_d;

  logic                  busy_q, busy_d;
  logic                  erase_q, erase_d;
  logic                  expose_q, expose_d;
  logic                  convert_q, convert_d;
  logic                  read1_q, read1_d;
  logic                  read2_q, read2_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [2*DATA_W-1:0]   out_pixel_q, out_pixel_d;
  logic                  out_row_q, out_row_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;

  logic                  handshake;
  logic [DATA_W-1:0]     ramp_bin;

  assign handshake = out_valid_q & out_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so that every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d takes a default before the case so that no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)                      state_d = ERASE;
      ERASE:   if (phase_cnt_q == ERASE_LAST)  state_d = EXPOSE;
      EXPOSE:  if (phase_cnt_q == EXPOSE_LAST) state_d = CONVERT;
      CONVERT: if (conv_cnt_q == CONV_LAST)    state_d = R1_SET;
      R1_SET:                                  state_d = R1_OUT;
      R1_OUT:  if (handshake)                  state_d = R2_SET;
      R2_SET:                                  state_d = R2_OUT;
      R2_OUT:  if (handshake)                  state_d = DONE;
      DONE:                                    state_d = IDLE;
      default:                                 state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath next-state logic. The outputs are registered, so they
  // are decoded from state_d and line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    phase_cnt_d  = 16'd0;
    conv_cnt_d   = '0;
    ramp_bin     = '0;
    data_d       = '0;
    out_pixel_d  = out_pixel_q;
    out_row_d    = out_row_q;
    out_valid_d  = out_valid_q;

    busy_d       = (state_d != IDLE);
    erase_d      = (state_d == ERASE);
    expose_d     = (state_d == EXPOSE);
    convert_d    = (state_d == CONVERT);
    read1_d      = (state_d == R1_SET) || (state_d == R1_OUT);
    read2_d      = (state_d == R2_SET) || (state_d == R2_OUT);
    frame_done_d = (state_d == DONE);

    // Phase counter restarts on every entry into ERASE or EXPOSE.
    if ((state_d == ERASE || state_d == EXPOSE) && (state_d == state_q)) begin
      phase_cnt_d = phase_cnt_q + 16'd1;
    end

    // The ramp starts at 0 on entry and counts once per cycle.
    if (state_d == CONVERT) begin
      if (state_q == CONVERT) begin
        conv_cnt_d = conv_cnt_q + 1'b1;
      end
      ramp_bin = conv_cnt_d[DATA_W-1:0];
`ifdef GRAY_CODE_EN
      data_d = ramp_bin ^ (ramp_bin >> 1);
`else
      data_d = ramp_bin;
`endif
    end

    // Column buses have settled after the SET cycle; capture on its exit edge.
    case (state_q)
      R1_SET: begin
        out_pixel_d = {col2_in, col1_in};
        out_row_d   = 1'b0;
        out_valid_d = 1'b1;
      end
      R2_SET: begin
        out_pixel_d = {col2_in, col1_in};
        out_row_d   = 1'b1;
        out_valid_d = 1'b1;
      end
      R1_OUT, R2_OUT: begin
        if (handshake) begin
          out_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_cnt_q  <= 16'd0;
      conv_cnt_q   <= '0;
      busy_q       <= 1'b0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read1_q      <= 1'b0;
      read2_q      <= 1'b0;
      data_q       <= '0;
      out_pixel_q  <= '0;
      out_row_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      phase_cnt_q  <= phase_cnt_d;
      conv_cnt_q   <= conv_cnt_d;
      busy_q       <= busy_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      read1_q      <= read1_d;
      read2_q      <= read2_d;
      data_q       <= data_d;
      out_pixel_q  <= out_pixel_d;
      out_row_q    <= out_row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = busy_q;
  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign read1      = read1_q;
  assign read2      = read2_q;
  assign data       = data_q;
  assign out_pixel  = out_pixel_q;
  assign out_row    = out_row_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_frame_ctrl
//
// Self-checking bench for pixel_frame_ctrl. The expected outputs for each
// cycle are derived from a timeline model. The model marks the phase
// boundaries from the phase lengths and stall counts. It then reads every
// output off the timeline.
// -----------------------------------------------------------------------------
module tb_pixel_frame_ctrl;

  localparam int E  = 5;
  localparam int X  = 255;
  localparam int DW = 8;
  localparam int C  = 1 << DW;

  typedef struct packed {
    logic          busy;
    logic          erase;
    logic          expose;
    logic          convert;
    logic          read1;
    logic          read2;
    logic [DW-1:0] data;
    logic [2*DW-1:0] pixel;
    logic          row;
    logic          valid;
    logic          done;
  } out_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            busy, erase, expose, convert, read1, read2;
  logic [DW-1:0]   data;
  logic [DW-1:0]   col1_in, col2_in;
  logic [2*DW-1:0] out_pixel;
  logic            out_row, out_valid, out_ready, frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Values the pixel output register holds before the next frame starts.
  logic [2*DW-1:0] prev_pix = '0;
  logic            prev_row = 1'b0;

  // Recorded by run_frame for scenario-level checks.
  int            first_done_t;
  int            done_count;
  logic [DW-1:0] rec_data [0:1023];

  pixel_frame_ctrl #(
    .ERASE_CYCLES (E),
    .EXPOSE_CYCLES(X),
    .DATA_W       (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .erase     (erase),
    .expose    (expose),
    .convert   (convert),
    .read1     (read1),
    .read2     (read2),
    .data      (data),
    .col1_in   (col1_in),
    .col2_in   (col2_in),
    .out_pixel (out_pixel),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t observe();
    out_t o;
    o = {busy, erase, expose, convert, read1, read2, data,
         out_pixel, out_row, out_valid, frame_done};
    return o;
  endfunction

  // The frame timeline, measured from the first erase cycle (t = 0).
  // s1 and s2 are the numbers of not-ready cycles seen in each output phase.
  function automatic out_t model(int t, int s1, int s2,
                                 logic [2*DW-1:0] pp, logic pr,
                                 logic [2*DW-1:0] p1, logic [2*DW-1:0] p2);
    out_t e;
    int cv, r1s, r1e, r2s, r2e, dn, k;
    logic [DW-1:0] v;
    cv  = E + X;
    r1s = cv + C;
    r1e = r1s + 1 + s1;
    r2s = r1e + 1;
    r2e = r2s + 1 + s2;
    dn  = r2e + 1;
    e = '0;
    e.pixel   = pp;
    e.row     = pr;
    if (t > r1s) begin e.pixel = p1; e.row = 1'b0; end
    if (t > r2s) begin e.pixel = p2; e.row = 1'b1; end
    e.busy    = (t <= dn);
    e.erase   = (t < E);
    e.expose  = (t >= E) && (t < cv);
    e.convert = (t >= cv) && (t < r1s);
    e.read1   = (t >= r1s) && (t <= r1e);
    e.read2   = (t >= r2s) && (t <= r2e);
    e.valid   = ((t > r1s) && (t <= r1e)) || ((t > r2s) && (t <= r2e));
    e.done    = (t == dn);
    if (e.convert) begin
      k = t - cv;
      v = k[DW-1:0];
`ifdef GRAY_CODE_EN
      e.data = v ^ (v >> 1);
`else
      e.data = v;
`endif
    end
    return e;
  endfunction

  // Runs one frame, comparing every cycle against the model. Inputs are
  // driven #1 after each rising edge, so they are sampled by the next edge.
  //   rs1/rs2  cycles at which start is re-pulsed (-1 = never)
  //   abort_t  cycle after which reset is pulled low mid-cycle (-1 = never)
  //   tail     idle cycles checked after frame_done
  task automatic run_frame(input int s1, input int s2,
                           input logic [DW-1:0] c1a, input logic [DW-1:0] c2a,
                           input logic [DW-1:0] c1b, input logic [DW-1:0] c2b,
                           input int rs1, input int rs2,
                           input int abort_t, input int tail);
    int r1s, r1e, r2s, r2e, dn;
    out_t exp_o, obs_o;
    logic [2*DW-1:0] p1, p2;
    r1s = E + X + C;
    r1e = r1s + 1 + s1;
    r2s = r1e + 1;
    r2e = r2s + 1 + s2;
    dn  = r2e + 1;
    p1  = {c2a, c1a};
    p2  = {c2b, c1b};
    first_done_t = -1;
    done_count   = 0;

    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = 1'($urandom);
    col1_in   = 8'($urandom);
    col2_in   = 8'($urandom);

    for (int t = 0; t <= dn + tail; t++) begin
      @(posedge clk); #1;
      obs_o = observe();
      exp_o = model(t, s1, s2, prev_pix, prev_row, p1, p2);
      if (t < 1024) rec_data[t] = data;
      if (frame_done) begin
        done_count++;
        if (first_done_t < 0) first_done_t = t;
      end
      n_checks++;
      if (obs_o !== exp_o) begin
        $display("FAIL frame_cycle t=%0d got=%h exp=%h", t, obs_o, exp_o);
      end else begin
        n_pass++;
      end

      if (t == abort_t) begin
        #2 reset = 1'b0;
        #1;
        obs_o = observe();
        n_checks++;
        if (obs_o !== '0) begin
          $display("FAIL abort_outputs t=%0d got=%h exp=0", t, obs_o);
        end else begin
          n_pass++;
        end
        start    = 1'b0;
        prev_pix = '0;
        prev_row = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        return;
      end

      start = ((t == rs1) || (t == rs2)) ? 1'b1 : 1'b0;
      if (t > r1s && t <= r1e)      out_ready = (t == r1e);
      else if (t > r2s && t <= r2e) out_ready = (t == r2e);
      else                          out_ready = 1'($urandom);
      if (t == r1s) begin
        col1_in = c1a; col2_in = c2a;
      end else if (t == r2s) begin
        col1_in = c1b; col2_in = c2b;
      end else begin
        col1_in = 8'($urandom); col2_in = 8'($urandom);
      end
    end
    start    = 1'b0;
    prev_pix = p2;
    prev_row = 1'b1;
  endtask

  task automatic test_reset();
    out_t obs_o;
    reset     = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    col1_in   = 8'h5A;
    col2_in   = 8'hC3;
    repeat (3) @(posedge clk);
    #1;
    obs_o = observe();
    n_checks++;
    if (obs_o !== '0) begin
      $display("FAIL reset_outputs got=%h exp=0", obs_o);
    end else begin
      n_pass++;
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs_o = observe();
    n_checks++;
    if (obs_o !== '0) begin
      $display("FAIL idle_after_reset got=%h exp=0", obs_o);
    end else begin
      n_pass++;
    end
  endtask

  task automatic test_nominal();
    logic [DW-1:0] d387, d515;
`ifdef GRAY_CODE_EN
    d387 = 8'h40; d515 = 8'h80;
`else
    d387 = 8'h7F; d515 = 8'hFF;
`endif
    run_frame(0, 0, 8'h3C, 8'hA5, 8'h11, 8'h22, -1, -1, -1, 3);
    n_checks++;
    if (first_done_t !== 520) begin
      $display("FAIL nominal_done_cycle got=%0d exp=520", first_done_t);
    end else n_pass++;
    n_checks++;
    if (rec_data[260] !== 8'h00) begin
      $display("FAIL ramp_first got=%h exp=00", rec_data[260]);
    end else n_pass++;
    n_checks++;
    if (rec_data[387] !== d387) begin
      $display("FAIL ramp_mid got=%h exp=%h", rec_data[387], d387);
    end else n_pass++;
    n_checks++;
    if (rec_data[515] !== d515) begin
      $display("FAIL ramp_last got=%h exp=%h", rec_data[515], d515);
    end else n_pass++;
    n_checks++;
    if (rec_data[516] !== 8'h00) begin
      $display("FAIL ramp_after got=%h exp=00", rec_data[516]);
    end else n_pass++;
    n_checks++;
    if (out_pixel !== 16'h2211 || out_row !== 1'b1) begin
      $display("FAIL final_capture got=%h/%b exp=2211/1", out_pixel, out_row);
    end else n_pass++;
  endtask

  task automatic test_backpressure();
    run_frame(10, 0, 8'h3C, 8'hA5, 8'h11, 8'h22, -1, -1, -1, 3);
    n_checks++;
    if (first_done_t !== 530) begin
      $display("FAIL stalled_done_cycle got=%0d exp=530", first_done_t);
    end else n_pass++;
  endtask

  task automatic test_random_frames();
    for (int i = 0; i < 3; i++) begin
      run_frame(int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                -1, -1, -1, int'($urandom_range(1, 6)));
    end
  endtask

  task automatic test_start_ignored();
    int dn;
    dn = E + X + C + 4;
    run_frame(0, 0, 8'h01, 8'h02, 8'h03, 8'h04, E + 20, dn, -1, 20);
    n_checks++;
    if (done_count !== 1) begin
      $display("FAIL single_frame_done got=%0d exp=1", done_count);
    end else n_pass++;
  endtask

  task automatic test_reset_midframe();
    run_frame(0, 0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, -1, -1, 300, 0);
    n_checks++;
    if (done_count !== 0) begin
      $display("FAIL abort_no_done got=%0d exp=0", done_count);
    end else n_pass++;
    run_frame(0, 0, 8'h3C, 8'hA5, 8'h11, 8'h22, -1, -1, -1, 3);
    n_checks++;
    if (first_done_t !== 520) begin
      $display("FAIL restart_done_cycle got=%0d exp=520", first_done_t);
    end else n_pass++;
  endtask

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    col1_in   = '0;
    col2_in   = '0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_random_frames();
    test_start_ignored();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
